// File: rtl/control_sequencer.sv
// Hardwired control sequencer for the datapath: fetch (T0-T2), decode of the
// instruction register, then execute (T3-T6). Outputs are Moore-decoded from
// the state register and the instruction register contents.
module control_sequencer #(
   parameter logic [4:0] OpMul  = 5'b01111,
   parameter logic [4:0] OpDiv  = 5'b10000,
   parameter logic [4:0] OpNeg  = 5'b10001,
   parameter logic [4:0] OpNot  = 5'b10010,
   parameter logic [4:0] OpNop  = 5'b11010,
   parameter logic [4:0] OpHalt = 5'b11011
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        run,
   input  logic        mem_rdy,
   input  logic [31:0] ir,
   output logic        pc_out,
   output logic        zlo_out,
   output logic        zhi_out,
   output logic        mdr_out,
   output logic        mar_enable,
   output logic        mdr_enable,
   output logic        ir_enable,
   output logic        y_enable,
   output logic        z_enable,
   output logic        lo_enable,
   output logic        hi_enable,
   output logic        pc_increment,
   output logic        read,
   output logic [4:0]  op_code,
   output logic [15:0] reg_in,
   output logic [15:0] reg_out,
   output logic        halted,
   output logic        illegal
);

   typedef enum logic [3:0] {
      StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StHalt
   } state_e;

   state_e state_q;
   state_e end_st;

   logic [4:0] op;
   logic [3:0] ra, rb, rc;
   logic       is_alu, is_muldiv, is_unary, is_nop, is_halt;
   logic       unused_ir_bits;

   assign op = ir[31:27];
   assign ra = ir[26:23];
   assign rb = ir[22:19];
   assign rc = ir[18:15];
   assign unused_ir_bits = ^ir[14:0];

   assign is_alu    = (op < OpMul);
   assign is_muldiv = (op == OpMul) || (op == OpDiv);
   assign is_unary  = (op == OpNeg) || (op == OpNot);
   assign is_nop    = (op == OpNop);
   assign is_halt   = (op == OpHalt);

   // Where the last execute cycle of an instruction goes.
   assign end_st = run ? StT0 : StIdle;

   // State sequencing; clr aborts any instruction in flight.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= StIdle;
      end else begin
         unique case (state_q)
            StIdle: state_q <= run ? StT0 : StIdle;
            StT0:   state_q <= StT1;
            StT1:   state_q <= mem_rdy ? StT2 : StT1;
            StT2:   state_q <= StT3;
            StT3: begin
               if (is_halt) begin
                  state_q <= StHalt;
               end else if (is_alu || is_muldiv || is_unary) begin
                  state_q <= StT4;
               end else begin
                  state_q <= end_st;
               end
            end
            StT4:   state_q <= (is_alu || is_muldiv) ? StT5 : end_st;
            StT5:   state_q <= is_muldiv ? StT6 : end_st;
            StT6:   state_q <= end_st;
            StHalt: state_q <= StHalt;
            default: state_q <= StIdle;
         endcase
      end
   end

   // Control decode. IR is loaded on the edge leaving T2, so the decode has to
   // follow ir combinationally rather than being captured on that same edge.
   always_comb begin
      pc_out       = 1'b0;
      zlo_out      = 1'b0;
      zhi_out      = 1'b0;
      mdr_out      = 1'b0;
      mar_enable   = 1'b0;
      mdr_enable   = 1'b0;
      ir_enable    = 1'b0;
      y_enable     = 1'b0;
      z_enable     = 1'b0;
      lo_enable    = 1'b0;
      hi_enable    = 1'b0;
      pc_increment = 1'b0;
      read         = 1'b0;
      op_code      = 5'b0;
      reg_in       = 16'b0;
      reg_out      = 16'b0;
      halted       = 1'b0;
      illegal      = 1'b0;
      unique case (state_q)
         StT0: begin
            pc_out       = 1'b1;
            mar_enable   = 1'b1;
            pc_increment = 1'b1;
         end
         StT1: begin
            read       = 1'b1;
            mdr_enable = 1'b1;
         end
         StT2: begin
            mdr_out   = 1'b1;
            ir_enable = 1'b1;
         end
         StT3: begin
            if (is_alu) begin
               reg_out  = 16'b1 << rb;
               y_enable = 1'b1;
            end else if (is_muldiv) begin
               reg_out  = 16'b1 << ra;
               y_enable = 1'b1;
            end else if (is_unary) begin
               reg_out  = 16'b1 << rb;
               op_code  = op;
               z_enable = 1'b1;
            end else if (!is_nop && !is_halt) begin
               illegal = 1'b1;
            end
         end
         StT4: begin
            if (is_alu) begin
               reg_out  = 16'b1 << rc;
               op_code  = op;
               z_enable = 1'b1;
            end else if (is_muldiv) begin
               reg_out  = 16'b1 << rb;
               op_code  = op;
               z_enable = 1'b1;
            end else if (is_unary) begin
               zlo_out = 1'b1;
               reg_in  = 16'b1 << ra;
            end
         end
         StT5: begin
            if (is_alu) begin
               zlo_out = 1'b1;
               reg_in  = 16'b1 << ra;
            end else if (is_muldiv) begin
               zlo_out   = 1'b1;
               lo_enable = 1'b1;
            end
         end
         StT6: begin
            if (is_muldiv) begin
               zhi_out   = 1'b1;
               hi_enable = 1'b1;
            end
         end
         StHalt: halted = 1'b1;
         default: ;
      endcase
   end

endmodule
